// File: rtl/sdram_arb_pkg.sv
// Shared encodings and default sizing for the SDRAM arbiter and its refresh timer.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_REF  = 2'b01,
    CMD_WR   = 2'b10,
    CMD_RD   = 2'b11
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_IDLE  = 2'b01,
    ST_ISSUE = 2'b10,
    ST_WAIT  = 2'b11
  } state_e;

  localparam int REF_PERIOD_DEF = 1040;
  localparam int BURST_LEN_DEF  = 256;
  localparam int RD_THRESH_DEF  = 256;

  // Start address of the last row of a frame; the write pointer wraps after it.
  localparam logic [15:0] FRAME_LAST_ADDR = 16'hFF00;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises ref_pend every REF_PERIOD clocks and flags a
// sticky overrun when an interval elapses while the previous refresh is still pending.
module sdram_ref_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ref_ack,
  output logic ref_pend_o,
  output logic ref_overrun_o
);

  localparam int TW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REF_PERIOD - 1);

  logic [TW-1:0] timer_q, timer_d;
  logic          ref_pend_q, ref_pend_d;
  logic          overrun_q, overrun_d;
  logic          expire;

  always_comb begin
    timer_d = timer_q;
    expire  = 1'b0;
    if (en) begin
      if (timer_q == '0) begin
        timer_d = RELOAD;
        expire  = 1'b1;
      end else begin
        timer_d = timer_q - TW'(1);
      end
    end
    // An expiry in the same cycle as the acknowledge starts a fresh request.
    ref_pend_d = (ref_pend_q && !ref_ack) || expire;
    overrun_d  = overrun_q || (expire && ref_pend_q && !ref_ack);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= RELOAD;
      ref_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      ref_pend_q <= ref_pend_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ref_pend_o    = ref_pend_q;
  assign ref_overrun_o = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Fixed-priority SDRAM command arbiter (refresh > display read > camera write) with
// row-burst address pointers and a one-command-at-a-time issue/wait handshake.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int REF_PERIOD = REF_PERIOD_DEF,
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int RD_THRESH  = RD_THRESH_DEF
) (
  input  logic        clk_133M_i,
  input  logic        rst_133i,
  input  logic        init_done_i,
  input  logic [10:0] wr_fifo_used_i,
  input  logic [10:0] rd_fifo_used_i,
  input  logic        rd_en_i,
  output logic        cmd_valid_o,
  output logic [1:0]  cmd_type_o,
  output logic [15:0] cmd_addr_o,
  input  logic        cmd_ready_i,
  input  logic        cmd_done_i,
  output logic        busy_o,
  output logic        wr_frame_o,
  output logic        ref_overrun_o
);

  localparam logic [15:0] BURST_STEP = 16'(BURST_LEN);
  localparam logic [10:0] WR_LEVEL   = 11'(BURST_LEN);
  localparam logic [10:0] RD_LEVEL   = 11'(RD_THRESH);

  state_e      state_q, state_d;
  cmd_type_e   cmd_type_q, cmd_type_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        wr_frame_q, wr_frame_d;
  logic        ref_pend, ref_ack, timer_en;
  logic        rd_req, wr_req, rd_active;

  assign timer_en = (state_q != ST_INIT);
  assign ref_ack  = (state_q == ST_ISSUE) && (cmd_type_q == CMD_REF) && cmd_ready_i;
  assign rd_req   = rd_en_i && (rd_fifo_used_i <= RD_LEVEL);
  assign wr_req   = (wr_fifo_used_i >= WR_LEVEL);

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .clk           (clk_133M_i),
    .rst           (rst_133i),
    .en            (timer_en),
    .ref_ack       (ref_ack),
    .ref_pend_o    (ref_pend),
    .ref_overrun_o (ref_overrun_o)
  );

  always_comb begin
    state_d    = state_q;
    cmd_type_d = cmd_type_q;
    cmd_addr_d = cmd_addr_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    wr_frame_d = 1'b0;
    rd_active  = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (cmd_type_q == CMD_RD);

    case (state_q)
      ST_INIT: begin
        if (init_done_i) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ref_pend) begin
          cmd_type_d = CMD_REF;
          cmd_addr_d = '0;
          state_d    = ST_ISSUE;
        end else if (rd_req) begin
          cmd_type_d = CMD_RD;
          cmd_addr_d = rd_addr_q;
          state_d    = ST_ISSUE;
        end else if (wr_req) begin
          cmd_type_d = CMD_WR;
          cmd_addr_d = wr_addr_q;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_done_i) begin
          state_d = ST_IDLE;
          if (cmd_type_q == CMD_WR) begin
            if (wr_addr_q == FRAME_LAST_ADDR) begin
              wr_addr_d  = '0;
              wr_frame_d = 1'b1;
            end else begin
              wr_addr_d = wr_addr_q + BURST_STEP;
            end
          end else if (cmd_type_q == CMD_RD) begin
            rd_addr_d = rd_addr_q + BURST_STEP;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase

    // The display pointer restarts at the frame top whenever the display path is idle.
    if (!rd_en_i && !rd_active) rd_addr_d = '0;
  end

  always_ff @(posedge clk_133M_i) begin
    if (rst_133i) begin
      state_q    <= ST_INIT;
      cmd_type_q <= CMD_NONE;
      cmd_addr_q <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_type_q <= cmd_type_d;
      cmd_addr_q <= cmd_addr_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_frame_q <= wr_frame_d;
    end
  end

  assign cmd_valid_o = (state_q == ST_ISSUE);
  assign cmd_type_o  = (state_q == ST_ISSUE) ? cmd_type_q : CMD_NONE;
  assign cmd_addr_o  = (state_q == ST_ISSUE) ? cmd_addr_q : 16'h0000;
  assign busy_o      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign wr_frame_o  = wr_frame_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: arbitration vector table plus directed
// sequences for init gating, handshake stability, frame wrap, refresh overrun and reset.
module tb_sdram_arbiter;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_REF  = 2'b01;
  localparam logic [1:0] T_WR   = 2'b10;
  localparam logic [1:0] T_RD   = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [10:0] wr_used;
  logic [10:0] rd_used;
  logic        rd_en;
  logic        cmd_valid_o;
  logic [1:0]  cmd_type_o;
  logic [15:0] cmd_addr_o;
  logic        cmd_ready;
  logic        cmd_done;
  logic        busy_o;
  logic        wr_frame_o;
  logic        ref_overrun_o;

  always #5 clk = ~clk;

  sdram_arbiter dut (
    .clk_133M_i     (clk),
    .rst_133i       (rst),
    .init_done_i    (init_done),
    .wr_fifo_used_i (wr_used),
    .rd_fifo_used_i (rd_used),
    .rd_en_i        (rd_en),
    .cmd_valid_o    (cmd_valid_o),
    .cmd_type_o     (cmd_type_o),
    .cmd_addr_o     (cmd_addr_o),
    .cmd_ready_i    (cmd_ready),
    .cmd_done_i     (cmd_done),
    .busy_o         (busy_o),
    .wr_frame_o     (wr_frame_o),
    .ref_overrun_o  (ref_overrun_o)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [15:0] addr;
  } exp_t;

  typedef struct {
    logic        rd_en;
    logic [10:0] rd_used;
    logic [10:0] wr_used;
    logic        has_cmd;
    logic [1:0]  typ;
    logic [15:0] addr;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   frame_cnt = 0;

  always @(negedge clk) if (wr_frame_o === 1'b1) frame_cnt <= frame_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    init_done = 1'b0;
    wr_used   = '0;
    rd_used   = '0;
    rd_en     = 1'b0;
    cmd_ready = 1'b0;
    cmd_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int t;
    t = 0;
    while (cmd_valid_o !== 1'b1 && t < 3000) begin
      tick();
      t++;
    end
    ok = (cmd_valid_o === 1'b1);
    if (!ok) check("cmd_valid_timeout", 32'd0, 32'd1);
  endtask

  // Serves commands until the one at the scoreboard head has been matched;
  // refreshes that interleave unexpectedly are accepted when allow_ref is set.
  task automatic serve(input int hold, input int lat, input bit allow_ref);
    exp_t        e;
    bit          ok, matched;
    logic [1:0]  ty;
    logic [15:0] ad;
    int          unstable;
    matched = 1'b0;
    while (!matched) begin
      wait_valid(ok);
      if (!ok) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        return;
      end
      ty = cmd_type_o;
      ad = cmd_addr_o;
      check("issue_busy", 32'(busy_o), 32'd1);
      if (allow_ref && ty == T_REF && exp_q.size() > 0 && exp_q[0].typ != T_REF) begin
        check("ref_addr", 32'(ad), 32'd0);
      end else begin
        matched = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 32'(ty), 32'(T_NONE));
        end else begin
          e = exp_q.pop_front();
          check("cmd_type", 32'(ty), 32'(e.typ));
          check("cmd_addr", 32'(ad), 32'(e.addr));
        end
      end
      unstable = 0;
      repeat (hold) begin
        tick();
        if (cmd_valid_o !== 1'b1 || cmd_type_o !== ty || cmd_addr_o !== ad) unstable++;
      end
      if (hold > 0) check("issue_stable", 32'(unstable), 32'd0);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("wait_state", {30'd0, cmd_valid_o, busy_o}, 32'b01);
      repeat (lat) tick();
      cmd_done = 1'b1;
      tick();
      cmd_done = 1'b0;
      check("idle_after_done", {30'd0, cmd_valid_o, busy_o}, 32'b00);
    end
  endtask

  initial begin
    bit ok;
    int cnt;
    int f0;

    vecs[0] = '{rd_en: 1'b0, rd_used: 11'd0,   wr_used: 11'd600, has_cmd: 1'b1, typ: T_WR, addr: 16'h0000};
    vecs[1] = '{rd_en: 1'b1, rd_used: 11'd100, wr_used: 11'd300, has_cmd: 1'b1, typ: T_RD, addr: 16'h0000};
    vecs[2] = '{rd_en: 1'b1, rd_used: 11'd256, wr_used: 11'd0,   has_cmd: 1'b1, typ: T_RD, addr: 16'h0000};
    vecs[3] = '{rd_en: 1'b1, rd_used: 11'd257, wr_used: 11'd256, has_cmd: 1'b1, typ: T_WR, addr: 16'h0000};
    vecs[4] = '{rd_en: 1'b1, rd_used: 11'd257, wr_used: 11'd255, has_cmd: 1'b0, typ: T_NONE, addr: 16'h0000};
    vecs[5] = '{rd_en: 1'b0, rd_used: 11'd0,   wr_used: 11'd255, has_cmd: 1'b0, typ: T_NONE, addr: 16'h0000};

    // Reset state
    do_reset();
    check("reset_outputs", {13'd0, cmd_valid_o, cmd_type_o, cmd_addr_o},
          32'd0);
    check("reset_flags", {29'd0, busy_o, wr_frame_o, ref_overrun_o}, 32'd0);

    // Arbitration table
    for (int i = 0; i < 6; i++) begin
      do_reset();
      rd_en     = vecs[i].rd_en;
      rd_used   = vecs[i].rd_used;
      wr_used   = vecs[i].wr_used;
      init_done = 1'b1;
      if (vecs[i].has_cmd) begin
        exp_q.push_back('{typ: vecs[i].typ, addr: vecs[i].addr});
        serve(0, 1, 1'b1);
      end else begin
        cnt = 0;
        repeat (20) begin
          tick();
          if (cmd_valid_o !== 1'b0) cnt++;
        end
        check($sformatf("vec%0d_no_cmd", i), 32'(cnt), 32'd0);
      end
    end

    // Init gating, then the first write lands at the frame start
    do_reset();
    wr_used = 11'd600;
    cnt = 0;
    repeat (50) begin
      tick();
      if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) cnt++;
    end
    check("init_no_cmd", 32'(cnt), 32'd0);
    init_done = 1'b1;
    exp_q.push_back('{typ: T_WR, addr: 16'h0000});
    serve(0, 1, 1'b1);

    // Read beats write, read pointer advances, turnaround is two cycles
    do_reset();
    wr_used = 11'd300; rd_en = 1'b1; rd_used = 11'd100; init_done = 1'b1;
    exp_q.push_back('{typ: T_RD, addr: 16'h0000});
    serve(0, 2, 1'b1);
    tick();
    check("turnaround_valid", 32'(cmd_valid_o), 32'd1);
    exp_q.push_back('{typ: T_RD, addr: 16'h0100});
    serve(20, 1, 1'b1);
    rd_used = 11'd1000;
    exp_q.push_back('{typ: T_WR, addr: 16'h0000});
    serve(0, 1, 1'b1);

    // Full frame of writes: wr_frame pulses once, after the 0xFF00 burst
    do_reset();
    wr_used = 11'd600; init_done = 1'b1;
    f0 = frame_cnt;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back('{typ: T_WR, addr: 16'(i * 256)});
      serve(0, 1, 1'b1);
      if (i == 254) check("frame_early", 32'(frame_cnt - f0), 32'd0);
    end
    check("frame_pulse", 32'(wr_frame_o), 32'd1);
    tick();
    check("frame_single", 32'(wr_frame_o), 32'd0);
    check("frame_count", 32'(frame_cnt - f0), 32'd1);
    exp_q.push_back('{typ: T_WR, addr: 16'h0000});
    serve(0, 1, 1'b1);

    // Withheld completion causes refresh overrun; refresh goes next
    do_reset();
    wr_used = 11'd600; init_done = 1'b1;
    wait_valid(ok);
    check("ovr_first_type", 32'(cmd_type_o), 32'(T_WR));
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    repeat (1500) tick();
    check("ovr_not_yet", 32'(ref_overrun_o), 32'd0);
    repeat (700) tick();
    check("ovr_set", 32'(ref_overrun_o), 32'd1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    exp_q.push_back('{typ: T_REF, addr: 16'h0000});
    serve(0, 1, 1'b0);
    repeat (5) tick();
    check("ovr_sticky", 32'(ref_overrun_o), 32'd1);
    do_reset();
    check("ovr_cleared", 32'(ref_overrun_o), 32'd0);

    // Reset mid-command, pointers restart from zero
    do_reset();
    wr_used = 11'd600; rd_en = 1'b1; rd_used = 11'd100; init_done = 1'b1;
    exp_q.push_back('{typ: T_RD, addr: 16'h0000});
    serve(0, 1, 1'b1);
    rd_used = 11'd1000;
    exp_q.push_back('{typ: T_WR, addr: 16'h0000});
    serve(0, 1, 1'b1);
    wait_valid(ok);
    check("pre_rst_addr", 32'(cmd_addr_o), 32'h0100);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("pre_rst_wait", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    init_done = 1'b0;
    check("rst_wait_outputs", {13'd0, cmd_valid_o, cmd_type_o, cmd_addr_o}, 32'd0);
    check("rst_wait_flags", {29'd0, busy_o, wr_frame_o, ref_overrun_o}, 32'd0);
    cnt = 0;
    repeat (10) begin
      tick();
      if (cmd_valid_o !== 1'b0 || busy_o !== 1'b0) cnt++;
    end
    check("rst_stays_init", 32'(cnt), 32'd0);
    rd_used = 11'd100; init_done = 1'b1;
    exp_q.push_back('{typ: T_RD, addr: 16'h0000});
    serve(0, 1, 1'b1);
    rd_used = 11'd1000;
    exp_q.push_back('{typ: T_WR, addr: 16'h0000});
    serve(0, 1, 1'b1);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
